// File: rtl/stat_graph_render_pkg.sv
// Shared types and defaults for the statistics graph renderer.
package stat_graph_render_pkg;

    typedef logic [10:0] pos_t;
    typedef logic [9:0]  vcount_t;
    typedef logic [11:0] color_t;

    localparam int              DEFAULT_NUM_CH     = 2;
    // Channel 0 occupies the low 12 bits: channel 0 green, channel 1 red.
    localparam logic [23:0]     DEFAULT_CH_COLORS  = {12'hF00, 12'h0F0};
    localparam color_t          DEFAULT_AXIS_COLOR = 12'hFFF;

endpackage

// File: rtl/stat_graph_render_history_ram.sv
// Per-channel sample history: synchronous write, asynchronous read.
module stat_history_ram #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 18,
    parameter int ADDR_W = 8
) (
    input  logic              clk_in,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto distributed RAM; the fill count masks stale slots.
    always_ff @(posedge clk_in) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stat_graph_render.sv
// Multi-channel per-frame event counter with a scrolling, auto-scaling history graph.
module stat_graph_render
    import stat_graph_render_pkg::*;
#(
    parameter int                   ORIGIN_X      = 342,
    parameter int                   ORIGIN_Y      = 20,
    parameter int                   WIDTH         = 256,
    parameter int                   HEIGHT        = 128,
    parameter int                   NUM_CH        = DEFAULT_NUM_CH,
    parameter int                   TALLY_WIDTH   = 18,
    parameter int                   SAMPLE_PERIOD = 4,
    parameter int                   BOARD_SIZE    = 320,
    parameter int                   ACTIVE_W      = BOARD_SIZE,
    parameter int                   ACTIVE_H      = BOARD_SIZE,
    parameter logic [NUM_CH*12-1:0] CH_COLORS     = DEFAULT_CH_COLORS,
    parameter color_t               AXIS_COLOR    = DEFAULT_AXIS_COLOR
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  pos_t              hcount_in,
    input  vcount_t           vcount_in,
    input  logic [NUM_CH-1:0] ch_event_in,
    input  logic              mode_in,
    input  logic              freeze_in,
    input  logic              clear_in,
    output color_t            pix_out
);

    localparam int PTR_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int FC_W    = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int SHIFT_W = $clog2(TALLY_WIDTH + 1);
    localparam int LOG2_H  = $clog2(HEIGHT);
    localparam int ZERO_Y  = ORIGIN_Y + HEIGHT;

    typedef logic [TALLY_WIDTH-1:0] tally_t;
    typedef logic [SHIFT_W-1:0]     shift_t;

    localparam tally_t             TALLY_MAX = '1;
    localparam logic [PTR_W-1:0]   PTR_LAST  = PTR_W'(WIDTH - 1);
    localparam logic [FILL_W-1:0]  FILL_FULL = FILL_W'(WIDTH);
    localparam logic [FC_W-1:0]    FC_LAST   = FC_W'(SAMPLE_PERIOD - 1);

    function automatic int bitlen(input tally_t v);
        bitlen = 0;
        for (int i = 0; i < TALLY_WIDTH; i++) begin
            if (v[i]) bitlen = i + 1;
        end
    endfunction

    int hx, vy, col_off, rd_sum, bl;
    int bar_h [NUM_CH];
    logic in_active, frame_end, commit, hist_we, in_cols, col_valid, scale_row;
    logic on_axis;
    logic [PTR_W-1:0]  wr_ptr, rd_addr;
    logic [FILL_W-1:0] fill;
    logic [FC_W-1:0]   frame_cnt;
    shift_t            s, s_next;
    tally_t            tally [NUM_CH];
    tally_t            rd_data [NUM_CH];
    tally_t            sample [NUM_CH];
    tally_t            samp_max, run_max;
    color_t            pix_next;

    assign hx        = int'(hcount_in);
    assign vy        = int'(vcount_in);
    assign in_active = (hx < ACTIVE_W) && (vy < ACTIVE_H);
    assign frame_end = (hx == ACTIVE_W) && (vy == ACTIVE_H);
    assign commit    = frame_end && !freeze_in && (frame_cnt == FC_LAST);
    assign hist_we   = commit && !clear_in;
    assign col_off   = hx - ORIGIN_X;
    assign in_cols   = (col_off >= 0) && (col_off < WIDTH);
    assign col_valid = in_cols && (col_off >= WIDTH - int'(fill));
    assign scale_row = (vy == ORIGIN_Y - 1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (!rst_n_in || frame_end) begin
                tally[c] <= '0;
            end else if (in_active && ch_event_in[c] && tally[c] != TALLY_MAX) begin
                tally[c] <= tally[c] + 1'b1;
            end
        end
    end

    // Frozen frames park frame_cnt on its last value so the first thawed frame end commits.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in || clear_in) begin
            wr_ptr    <= '0;
            fill      <= '0;
            frame_cnt <= '0;
        end else if (frame_end) begin
            if (frame_cnt != FC_LAST) begin
                frame_cnt <= frame_cnt + 1'b1;
            end else if (!freeze_in) begin
                frame_cnt <= '0;
            end
            if (commit) begin
                wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
                if (fill != FILL_FULL) fill <= fill + 1'b1;
            end
        end
    end

    // Oldest sample sits at column 0: slot (wr_ptr + x) mod WIDTH.
    always_comb begin
        rd_sum = int'(wr_ptr) + col_off;
        if (rd_sum >= WIDTH) rd_sum = rd_sum - WIDTH;
        rd_addr = rd_sum[PTR_W-1:0];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        stat_history_ram #(
            .DEPTH  (WIDTH),
            .DATA_W (TALLY_WIDTH),
            .ADDR_W (PTR_W)
        ) u_ram (
            .clk_in (clk_in),
            .we     (hist_we),
            .waddr  (wr_ptr),
            .wdata  (tally[c]),
            .raddr  (rd_addr),
            .rdata  (rd_data[c])
        );
        assign sample[c] = col_valid ? rd_data[c] : '0;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        samp_max = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (sample[c] > samp_max) samp_max = sample[c];
        end
        bl     = bitlen(run_max);
        s_next = (bl > LOG2_H) ? shift_t'(bl - LOG2_H) : '0;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in || clear_in) begin
            s       <= '0;
            run_max <= '0;
        end else if (scale_row) begin
            if (col_off == 0) begin
                run_max <= samp_max;
            end else if (in_cols && samp_max > run_max) begin
                run_max <= samp_max;
            end
            if (col_off == WIDTH) s <= s_next;
        end
    end

    assign on_axis = ((vy == ZERO_Y) && (col_off >= -1) && (col_off < WIDTH)) ||
                     ((col_off == -1) && (vy >= ORIGIN_Y) && (vy <= ZERO_Y));

    // Walk channels from highest to lowest index so channel 0 lands on top.
    always_comb begin
        pix_next = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            bar_h[c] = int'(sample[c] >> s);
            if (col_valid && (mode_in ? (vy == ZERO_Y - 1 - bar_h[c])
                                      : (vy >= ZERO_Y - bar_h[c] && vy < ZERO_Y))) begin
                pix_next = CH_COLORS[c*12 +: 12];
            end
        end
        if (on_axis) pix_next = AXIS_COLOR;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) pix_out <= '0;
        else           pix_out <= pix_next;
    end

endmodule

// File: tb/tb_stat_graph_render.sv
// Directed bench: 4x8 graph at (10,10), 4x4 counted region, one commit per frame.
module tb_stat_graph_render;
    import stat_graph_render_pkg::*;

    localparam color_t GRN = 12'h0F0;
    localparam color_t RED = 12'hF00;
    localparam color_t WHT = 12'hFFF;
    localparam color_t BLK = 12'h000;

    logic       clk_in = 1'b0;
    logic       rst_n_in;
    pos_t       hcount_in;
    vcount_t    vcount_in;
    logic [1:0] ch_event_in;
    logic       mode_in, freeze_in, clear_in;
    color_t     pix_out, pix_sat;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk_in = ~clk_in;

    stat_graph_render #(
        .ORIGIN_X(10), .ORIGIN_Y(10), .WIDTH(4), .HEIGHT(8), .NUM_CH(2),
        .TALLY_WIDTH(18), .SAMPLE_PERIOD(1), .BOARD_SIZE(4), .ACTIVE_W(4), .ACTIVE_H(4)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .ch_event_in(ch_event_in), .mode_in(mode_in), .freeze_in(freeze_in),
        .clear_in(clear_in), .pix_out(pix_out)
    );

    stat_graph_render #(
        .ORIGIN_X(10), .ORIGIN_Y(10), .WIDTH(4), .HEIGHT(8), .NUM_CH(2),
        .TALLY_WIDTH(3), .SAMPLE_PERIOD(1), .BOARD_SIZE(4), .ACTIVE_W(4), .ACTIVE_H(4)
    ) dut_sat (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .hcount_in(hcount_in), .vcount_in(vcount_in),
        .ch_event_in(ch_event_in), .mode_in(mode_in), .freeze_in(freeze_in),
        .clear_in(clear_in), .pix_out(pix_sat)
    );

    task automatic check(input string tag, input color_t got, input color_t exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int h, input int v, input logic [1:0] ev);
        hcount_in   = pos_t'(h);
        vcount_in   = vcount_t'(v);
        ch_event_in = ev;
        @(posedge clk_in);
        #1;
    endtask

    // Events land on in-region pixels; the frame-end cycle carries events that must be ignored.
    task automatic commit_frame(input int n0, input int n1);
        int n;
        n = (n0 > n1) ? n0 : n1;
        for (int i = 0; i < n; i++) step(i % 4, (i / 4) % 4, {i < n1, i < n0});
        step(0, 5, 2'b00);
        step(4, 4, 2'b11);
    endtask

    task automatic scale();
        for (int h = 10; h <= 14; h++) step(h, 9, 2'b00);
    endtask

    task automatic expect_pix(input string tag, input int h, input int v, input color_t exp);
        step(h, v, 2'b00);
        check(tag, pix_out, exp);
    endtask

    task automatic expect_sat(input string tag, input int h, input int v, input color_t exp);
        step(h, v, 2'b00);
        check(tag, pix_sat, exp);
    endtask

    initial begin
        rst_n_in = 1'b0; mode_in = 1'b0; freeze_in = 1'b0; clear_in = 1'b0;
        step(9, 18, 2'b00);
        check("reset_pix", pix_out, BLK);
        check("reset_pix_sat", pix_sat, BLK);
        step(9, 18, 2'b00);
        rst_n_in = 1'b1;

        // Single commit of 5, filled mode
        commit_frame(5, 0);
        scale();
        expect_pix("c3_top", 13, 13, GRN);
        expect_pix("c3_bot", 13, 17, GRN);
        expect_pix("c3_above", 13, 12, BLK);
        expect_pix("c2_blank", 12, 17, BLK);
        expect_pix("c0_blank", 10, 17, BLK);
        expect_pix("xaxis_l", 9, 18, WHT);
        expect_pix("xaxis_r", 13, 18, WHT);
        expect_pix("yaxis_top", 9, 10, WHT);
        expect_pix("xaxis_past", 14, 18, BLK);
        expect_pix("yaxis_above", 9, 9, BLK);

        // Grow to s=2, then shrink once the 16 ages out
        commit_frame(16, 0);
        scale();
        expect_pix("grow_c3_top", 13, 14, GRN);
        expect_pix("grow_c3_above", 13, 13, BLK);
        expect_pix("grow_c2_h1", 12, 17, GRN);
        expect_pix("grow_c2_above", 12, 16, BLK);
        for (int k = 0; k < 3; k++) begin
            commit_frame(0, 0);
            scale();
        end
        expect_pix("aged_c0_top", 10, 14, GRN);
        expect_pix("aged_c0_above", 10, 13, BLK);
        commit_frame(0, 0);
        scale();
        expect_pix("shrink_c0", 10, 17, BLK);
        expect_pix("shrink_c3", 13, 17, BLK);
        expect_pix("shrink_c1", 11, 17, BLK);

        // Wrap-around: 1..5 leaves 2,3,4,5 from left to right
        clear_in = 1'b1; step(0, 19, 2'b00); clear_in = 1'b0;
        for (int k = 1; k <= 5; k++) commit_frame(k, 0);
        scale();
        for (int x = 0; x < 4; x++) begin
            expect_pix($sformatf("wrap_c%0d_top", x), 10 + x, 16 - x, GRN);
            expect_pix($sformatf("wrap_c%0d_above", x), 10 + x, 15 - x, BLK);
        end

        // Overlap in line mode: channel 0 wins
        clear_in = 1'b1; step(0, 19, 2'b00); clear_in = 1'b0;
        mode_in = 1'b1;
        commit_frame(3, 3);
        scale();
        expect_pix("line_hit", 13, 14, GRN);
        expect_pix("line_below", 13, 15, BLK);
        expect_pix("line_above", 13, 13, BLK);
        expect_pix("line_c2_empty", 12, 14, BLK);
        commit_frame(0, 2);
        scale();
        expect_pix("line_ch1", 13, 15, RED);
        expect_pix("line_ch0_zero", 13, 17, GRN);
        expect_pix("line_c2_old", 12, 14, GRN);
        mode_in = 1'b0;

        // Freeze holds history; clear beats a simultaneous commit
        clear_in = 1'b1; step(0, 19, 2'b00); clear_in = 1'b0;
        commit_frame(2, 0);
        freeze_in = 1'b1;
        for (int k = 0; k < 3; k++) commit_frame(6, 0);
        scale();
        expect_pix("frz_top", 13, 16, GRN);
        expect_pix("frz_above", 13, 15, BLK);
        expect_pix("frz_c2_empty", 12, 17, BLK);
        freeze_in = 1'b0;
        for (int i = 0; i < 6; i++) step(i % 4, i / 4, 2'b01);
        clear_in = 1'b1; step(4, 4, 2'b00); clear_in = 1'b0;
        scale();
        expect_pix("clr_c3", 13, 17, BLK);
        expect_pix("clr_c3_hi", 13, 16, BLK);
        expect_pix("clr_axis", 9, 18, WHT);

        // Saturation: 20 events -> 7 in a 3-bit tally, 20 (s=2, h=5) in the wide one
        clear_in = 1'b1; step(0, 19, 2'b00); clear_in = 1'b0;
        commit_frame(20, 0);
        scale();
        expect_sat("sat_top", 13, 11, GRN);
        expect_sat("sat_above", 13, 10, BLK);
        expect_pix("wide_top", 13, 13, GRN);
        expect_pix("wide_above", 13, 12, BLK);

        // Mid-row reset empties the graph and restarts counting
        rst_n_in = 1'b0;
        step(13, 15, 2'b00);
        check("rst_pix", pix_out, BLK);
        check("rst_pix_sat", pix_sat, BLK);
        rst_n_in = 1'b1;
        expect_pix("rst_empty", 13, 15, BLK);
        expect_sat("rst_empty_sat", 13, 15, BLK);
        expect_pix("rst_axis", 9, 18, WHT);
        commit_frame(1, 0);
        scale();
        expect_pix("post_rst_h1", 13, 17, GRN);
        expect_pix("post_rst_above", 13, 16, BLK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
